// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences the instruction-fetch stage. It selects the PC source, enables the
//   PC write, handshakes with instruction memory and flushes IF/ID after a
//   control-flow redirect. Redirect priority is branch > jump_mem > jump, and any
//   redirect takes precedence over sequential PC+1.
//
//   State, timer and flush counter are registered. All outputs are Mealy, decoded
//   combinationally from the current state and the inputs.
//
// Parameters
//   FLUSH_CYCLES  bubbles inserted after a redirect, counting the redirect cycle (1..15)
//   TIMEOUT       WAIT cycles without imem_ack before fetch_err (1..255)
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   jump          redirect to the ALU_result target    (pc_sel 1)
//   jump_mem      redirect to the read_data target     (pc_sel 2)
//   branch        redirect to the rs1 target           (pc_sel 3)
//   stall         downstream hazard; hold PC and IF/ID
//   imem_ack      instruction memory data valid this cycle
//   pc_sel        0=PC+1, 1=ALU_result, 2=read_data, 3=rs1
//   pc_we         PC register load enable
//   imem_req      fetch request to instruction memory
//   if_valid      instruction on the imem data bus is valid for IF/ID
//   flush         kill IF/ID contents (insert bubble)
//   fetch_err     sticky memory-timeout error; cleared only by rst
//
// Optional feature (macro FETCH_PERF_EN)
//   redirect_cnt  saturating count of accepted redirects (pc_we=1 with pc_sel!=0)
//   stall_cnt     saturating count of FETCH/WAIT cycles with pc_we=0

module fetch_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump,
    input  logic       jump_mem,
    input  logic       branch,
    input  logic       stall,
    input  logic       imem_ack,
    output logic [1:0] pc_sel,
    output logic       pc_we,
    output logic       imem_req,
    output logic       if_valid,
    output logic       flush,
    output logic       fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] redirect_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_FLUSH,
        S_ERROR
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT);

    state_t     state, state_nx;
    logic [7:0] timer, timer_nx;
    logic [3:0] flush_cnt, flush_cnt_nx;

    logic       redir;
    logic [1:0] redir_sel;

    assign redir = branch | jump_mem | jump;

    always_comb begin
        if (branch)        redir_sel = 2'd3;
        else if (jump_mem) redir_sel = 2'd2;
        else               redir_sel = 2'd1;
    end

    // Next-state and Mealy output decode
    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        flush_cnt_nx = flush_cnt;
        pc_sel       = 2'd0;
        pc_we        = 1'b0;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        flush        = 1'b0;
        fetch_err    = 1'b0;

        case (state)
            S_BOOT: begin
                state_nx = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (redir) begin
                    pc_we        = 1'b1;
                    pc_sel       = redir_sel;
                    flush        = 1'b1;
                    flush_cnt_nx = FLUSH_RELOAD;
                    state_nx     = (FLUSH_CYCLES == 1) ? S_FETCH : S_FLUSH;
                end else if (stall) begin
                    state_nx = S_FETCH;
                end else if (imem_ack) begin
                    pc_we    = 1'b1;
                    if_valid = 1'b1;
                end else begin
                    timer_nx = 8'd1;
                    state_nx = S_WAIT;
                end
            end

            S_WAIT: begin
                imem_req = 1'b1;
                if (redir) begin
                    // Outstanding response is dropped; the flush kills whatever arrives.
                    pc_we        = 1'b1;
                    pc_sel       = redir_sel;
                    flush        = 1'b1;
                    flush_cnt_nx = FLUSH_RELOAD;
                    state_nx     = (FLUSH_CYCLES == 1) ? S_FETCH : S_FLUSH;
                end else if (imem_ack) begin
                    state_nx = S_FETCH;
                    if (!stall) begin
                        pc_we    = 1'b1;
                        if_valid = 1'b1;
                    end
                end else if (timer >= TIMEOUT_VAL) begin
                    // timer holds the number of WAIT cycles seen so far
                    state_nx = S_ERROR;
                end else if (timer != '1) begin
                    timer_nx = timer + 8'd1;
                end
            end

            S_FLUSH: begin
                imem_req = 1'b1;
                flush    = 1'b1;
                if (redir) begin
                    pc_we        = 1'b1;
                    pc_sel       = redir_sel;
                    flush_cnt_nx = FLUSH_RELOAD;
                end else begin
                    if (flush_cnt <= 4'd1) state_nx = S_FETCH;
                    flush_cnt_nx = (flush_cnt == '0) ? '0 : flush_cnt - 4'd1;
                end
            end

            S_ERROR: begin
                fetch_err = 1'b1;
            end

            default: begin
                state_nx = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_BOOT;
            timer     <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            flush_cnt <= flush_cnt_nx;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (pc_we && (pc_sel != 2'd0) && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + 16'd1;
            if (((state == S_FETCH) || (state == S_WAIT)) && !pc_we && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Directed bench for fetch_controller (FLUSH_CYCLES=2, TIMEOUT=4). Each step
//   drives the inputs, queues the expected output vector
//   {pc_sel, pc_we, imem_req, if_valid, flush, fetch_err}, and compares it on the
//   following falling edge. Define FETCH_PERF_EN to exercise the perf counters.

module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst, jump, jump_mem, branch, stall, imem_ack;
    logic [1:0] pc_sel;
    logic       pc_we, imem_req, if_valid, flush, fetch_err;
`ifdef FETCH_PERF_EN
    logic [15:0] redirect_cnt, stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] sb[$];

    // {pc_sel, pc_we, imem_req, if_valid, flush, fetch_err}
    localparam logic [6:0] O_BOOT  = 7'b00_0000_0;
    localparam logic [6:0] O_SEQ   = 7'b00_1110_0;
    localparam logic [6:0] O_REQ   = 7'b00_0100_0;
    localparam logic [6:0] O_FLUSH = 7'b00_0101_0;
    localparam logic [6:0] O_ERR   = 7'b00_0000_1;
    localparam logic [6:0] O_RD1   = 7'b01_1101_0;
    localparam logic [6:0] O_RD2   = 7'b10_1101_0;
    localparam logic [6:0] O_RD3   = 7'b11_1101_0;

    always #5 clk = ~clk;

    fetch_controller #(
        .FLUSH_CYCLES(2),
        .TIMEOUT     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .jump     (jump),
        .jump_mem (jump_mem),
        .branch   (branch),
        .stall    (stall),
        .imem_ack (imem_ack),
        .pc_sel   (pc_sel),
        .pc_we    (pc_we),
        .imem_req (imem_req),
        .if_valid (if_valid),
        .flush    (flush),
        .fetch_err(fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .redirect_cnt(redirect_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // One clock step: drive, queue expectation, compare at negedge, advance past posedge.
    task automatic apply(input logic r, input logic j, input logic jm, input logic b,
                         input logic s, input logic a, input logic [6:0] exp,
                         input string tag);
        logic [6:0] got, want;
        rst = r; jump = j; jump_mem = jm; branch = b; stall = s; imem_ack = a;
        sb.push_back(exp);
        @(negedge clk);
        got  = {pc_sel, pc_we, imem_req, if_valid, flush, fetch_err};
        want = sb.pop_front();
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef FETCH_PERF_EN
    task automatic check16(input logic [15:0] got, input logic [15:0] want, input string tag);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; jump = 1'b0; jump_mem = 1'b0; branch = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then a constant ack stream
        apply(0, 0, 0, 0, 0, 1, O_BOOT, "boot");
        for (int unsigned i = 0; i < 3; i++)
            apply(0, 0, 0, 0, 0, 1, O_SEQ, "seq_fetch");

        // jump + branch together: branch wins, then one FLUSH bubble
        apply(0, 1, 0, 1, 0, 1, O_RD3, "redir_prio");
        apply(0, 0, 0, 0, 0, 1, O_FLUSH, "flush_bubble");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "post_flush");

        // Ack low three cycles, then ack in WAIT
        apply(0, 0, 0, 0, 0, 0, O_REQ, "no_ack_fetch");
        apply(0, 0, 0, 0, 0, 0, O_REQ, "wait_1");
        apply(0, 0, 0, 0, 0, 0, O_REQ, "wait_2");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "wait_ack");

        // Timeout with TIMEOUT=4: four WAIT cycles, then sticky ERROR
        apply(0, 0, 0, 0, 0, 0, O_REQ, "to_fetch");
        for (int unsigned i = 0; i < 4; i++)
            apply(0, 0, 0, 0, 0, 0, O_REQ, "to_wait");
        apply(0, 0, 0, 0, 0, 0, O_ERR, "err_set");
        apply(0, 1, 1, 1, 1, 1, O_ERR, "err_ignores_inputs");
        apply(0, 0, 0, 0, 0, 1, O_ERR, "err_sticky");
        apply(1, 0, 0, 0, 0, 1, O_ERR, "err_until_edge");
        apply(0, 0, 0, 0, 0, 1, O_BOOT, "boot_after_err");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "fetch_after_err");

        // Stall holds PC; redirect overrides stall
        apply(0, 0, 0, 0, 1, 1, O_REQ, "stall_hold");
        apply(0, 0, 1, 0, 1, 1, O_RD2, "stall_redir");
        apply(0, 0, 0, 0, 0, 1, O_FLUSH, "stall_redir_flush");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "stall_redir_done");

        // Ack during stall in WAIT: back to FETCH without loading PC
        apply(0, 0, 0, 0, 0, 0, O_REQ, "sw_fetch");
        apply(0, 0, 0, 0, 1, 1, O_REQ, "sw_ack_stalled");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "sw_resume");

        // Redirect inside FLUSH reloads the counter
        apply(0, 1, 0, 0, 0, 1, O_RD1, "jump_redir");
        apply(0, 1, 0, 0, 0, 1, O_RD1, "flush_reredir");
        apply(0, 0, 0, 0, 0, 1, O_FLUSH, "flush_reload");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "flush_done");

        // Redirect from WAIT discards the outstanding request
        apply(0, 0, 0, 0, 0, 0, O_REQ, "wr_fetch");
        apply(0, 0, 1, 0, 0, 0, O_RD2, "wait_redir");
        apply(0, 0, 0, 0, 0, 0, O_FLUSH, "wait_redir_flush");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "wait_redir_done");

        // Reset in the middle of FLUSH
        apply(0, 1, 0, 0, 0, 1, O_RD1, "pre_rst_redir");
        apply(1, 0, 0, 0, 0, 1, O_FLUSH, "rst_in_flush");
        apply(0, 0, 0, 0, 0, 1, O_BOOT, "boot_after_flush_rst");
        apply(0, 0, 0, 0, 0, 1, O_SEQ, "fetch_after_flush_rst");

`ifdef FETCH_PERF_EN
        apply(1, 0, 0, 0, 0, 1, O_SEQ, "perf_rst");
        check16(redirect_cnt, 16'd0, "redirect_cnt_rst");
        check16(stall_cnt, 16'd0, "stall_cnt_rst");
        apply(0, 0, 0, 0, 0, 1, O_BOOT, "perf_boot");
        for (int unsigned i = 0; i < 5; i++)
            apply(0, 0, 0, 0, 1, 1, O_REQ, "perf_stall");
        for (int unsigned i = 0; i < 3; i++) begin
            apply(0, 1, 0, 0, 0, 1, O_RD1, "perf_redir");
            apply(0, 0, 0, 0, 0, 1, O_FLUSH, "perf_flush");
        end
        check16(redirect_cnt, 16'd3, "redirect_cnt");
        check16(stall_cnt, 16'd5, "stall_cnt");
        force dut.redirect_cnt = 16'hFFFF;
        #1;
        release dut.redirect_cnt;
        apply(0, 1, 0, 0, 0, 1, O_RD1, "perf_sat_redir");
        check16(redirect_cnt, 16'hFFFF, "redirect_cnt_sat");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
